cpc_rom_loader: RTL

//  Parametrised download engine: turns the mist_io ioctl byte stream into SDRAM writes for the CPC.

---
 rtl/cpc_rom_loader_pkg.sv | 40 ++++
 rtl/cpc_toggle_port.sv | 43 ++++
 rtl/cpc_rom_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpc_rom_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpc_loader_pkg
//  Description : Shared types and constants for the CPC download engine.
//                Holds the mode encoding, the system-ROM chunk-to-page table,
//                the fallback pages and the ASCII hex-digit decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpc_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ROM    = 3'd1,
        EXT    = 3'd2,
        TAP    = 3'd3,
        IGNORE = 3'd4
    } mode_t;

    // 16KB chunk c of the system ROM image lands on page ROM_PAGE_TBL[c%4]
    localparam logic [8:0] ROM_PAGE_TBL [4] = '{9'h000, 9'h100, 9'h107, 9'h1FF};
    localparam logic [8:0] PAGE_MALFORMED   = 9'h1EE;
    localparam logic [8:0] PAGE_MF2         = 9'h1FF;

    // Returns {valid, nibble} for an ASCII character in 0-9 / A-F
    function automatic logic [4:0] hex_nib(input logic [7:0] ascii);
        logic [7:0] t;
        t = 8'h00;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            t = ascii - 8'h30;
            return {1'b1, t[3:0]};
        end
        if (ascii >= 8'h41 && ascii <= 8'h46) begin
            t = ascii - 8'h37;
            return {1'b1, t[3:0]};
        end
        return 5'h00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpc_toggle_port.sv
`default_nettype none
// ============================================================================
//  Module      : cpc_toggle_port
//  Description : One toggle req/ack channel. Captures a payload on i_start,
//                toggles o_req and holds o_pend until the far side toggles
//                ack to match req.
//  Ports       : clk_sys, reset      - clock / sync active-high reset
//                i_start             - accept payload and issue one request
//                i_payload / o_q     - payload in / held payload out
//                i_ack / o_req       - toggle handshake
//                o_pend              - a request is outstanding
//  Revision    : 1.0 - initial release
// ============================================================================
module cpc_toggle_port #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [PAYLOAD_W-1:0] i_payload,
    input  logic                 i_ack,
    output logic                 o_req,
    output logic                 o_pend,
    output logic [PAYLOAD_W-1:0] o_q
);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // Resync phase to the far side so reset never creates a request
            o_req  <= i_ack;
            o_pend <= 1'b0;
            o_q    <= '0;
        end else if (i_start) begin
            o_q    <= i_payload;
            o_req  <= ~o_req;
            o_pend <= 1'b1;
        end else if (o_pend && (i_ack == o_req)) begin
            o_pend <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpc_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cpc_rom_loader
//  Description : Converts the mist_io ioctl byte stream into SDRAM writes
//                (system ROM, expansion ROMs) and tape writes (CDT), with
//                one byte in flight at a time and a per-bank ROM map.
//  Ports       : ioctl_*   - download stream in, ioctl_wait stall out
//                mem_*     - SDRAM toggle channel (addr {page,offset})
//                tape_*    - tape toggle channel
//                map_*     - ROM presence clear / registered lookup
//                ovf, busy - sticky overrun flag, activity status
//  Revision    : 1.0 - initial release
// ============================================================================
module cpc_rom_loader
    import cpc_loader_pkg::*;
#(
    parameter  int PAGE_W  = 9,
    parameter  int BANK_W  = 1,
    parameter  int IDX_ROM = 0,
    parameter  int IDX_EXT = 3,
    parameter  int IDX_TAP = 4,
    localparam int ADDR_W  = PAGE_W + 14
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [31:0]       ioctl_file_ext,
    output logic              ioctl_wait,
    input  logic [BANK_W-1:0] model,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BANK_W-1:0] mem_bank,
    output logic [7:0]        mem_din,
    output logic              tape_req,
    input  logic              tape_ack,
    output logic [ADDR_W-1:0] tape_addr,
    output logic [7:0]        tape_din,
    input  logic              map_clear,
    input  logic [BANK_W-1:0] map_bank,
    input  logic [7:0]        map_page,
    output logic              map_hit,
    output logic              ovf,
    output logic              busy
);

    localparam int         NBANKS    = 2 ** BANK_W;
    localparam int         MEM_W     = BANK_W + ADDR_W + 8;
    localparam logic [7:0] C_IDX_ROM = 8'(IDX_ROM);
    localparam logic [7:0] C_IDX_EXT = 8'(IDX_EXT);
    localparam logic [7:0] C_IDX_TAP = 8'(IDX_TAP);

    // 9-bit page value -> PAGE_W page: bit 8 becomes the page MSB
    function automatic logic [PAGE_W-1:0] to_page(input logic [8:0] v);
        logic [PAGE_W-1:0] p;
        p           = '0;
        p[7:0]      = v[7:0];
        p[PAGE_W-1] = v[8];
        return p;
    endfunction

    logic r_wr_d, r_dl_d, w_wr_rise, w_dl_rise;
    logic w_mem_pend, w_tape_pend, w_pend_any;
    logic w_in_idle, w_in_rom, w_in_ext, w_in_tap;
    mode_t r_mode, w_mode_nxt;

    assign w_wr_rise  = ioctl_wr & ~r_wr_d;
    assign w_dl_rise  = ioctl_download & ~r_dl_d;
    assign w_pend_any = w_mem_pend | w_tape_pend;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_d <= 1'b0;
            r_dl_d <= 1'b0;
        end else begin
            r_wr_d <= ioctl_wr;
            r_dl_d <= ioctl_download;
        end
    end

    // ---------------- mode FSM: state register ----------------
    always_ff @(posedge clk_sys) begin
        if (reset) r_mode <= IDLE;
        else       r_mode <= w_mode_nxt;
    end

    // ---------------- mode FSM: next state ----------------
    always_comb begin
        w_mode_nxt = r_mode;
        case (r_mode)
            IDLE: begin
                if (w_dl_rise) begin
                    if      (ioctl_index == C_IDX_ROM) w_mode_nxt = ROM;
                    else if (ioctl_index == C_IDX_EXT) w_mode_nxt = EXT;
                    else if (ioctl_index == C_IDX_TAP) w_mode_nxt = TAP;
                    else                               w_mode_nxt = IGNORE;
                end
            end
            // A pending byte is drained before the mode is released
            default: if (!ioctl_download && !w_pend_any) w_mode_nxt = IDLE;
        endcase
    end

    // ---------------- mode FSM: outputs ----------------
    always_comb begin
        w_in_idle = 1'b0;
        w_in_rom  = 1'b0;
        w_in_ext  = 1'b0;
        w_in_tap  = 1'b0;
        case (r_mode)
            IDLE:    w_in_idle = 1'b1;
            ROM:     w_in_rom  = 1'b1;
            EXT:     w_in_ext  = 1'b1;
            TAP:     w_in_tap  = 1'b1;
            default: ;
        endcase
    end

    // ---------------- expansion ROM page from file extension ----------------
    logic [4:0]        w_nib_hi, w_nib_lo;
    logic [8:0]        w_ext_page9;
    logic              w_ext_combo;
    logic [PAGE_W-1:0] r_page, w_ext_pg;
    logic              r_combo, r_fixed;

    assign w_nib_hi = hex_nib(ioctl_file_ext[15:8]);
    assign w_nib_lo = hex_nib(ioctl_file_ext[7:0]);

    always_comb begin
        w_ext_page9 = PAGE_MALFORMED;
        w_ext_combo = 1'b0;
        if (ioctl_file_ext[15:8] == 8'h5A && ioctl_file_ext[7:0] == 8'h5A) begin
            w_ext_page9 = 9'h000;
        end else if (ioctl_file_ext[15:8] == 8'h5A && ioctl_file_ext[7:0] == 8'h30) begin
            w_ext_page9 = 9'h000;
            w_ext_combo = 1'b1;
        end else if (w_nib_hi[4] && w_nib_lo[4]) begin
            w_ext_page9 = {1'b1, w_nib_hi[3:0], w_nib_lo[3:0]};
        end
    end

    // Once a combo image switches over, the page is used as-is
    always_comb begin
        w_ext_pg = r_page;
        if (!r_fixed) w_ext_pg[7:0] = r_page[7:0] + ioctl_addr[21:14];
    end

    // ---------------- system ROM chunk mapping ----------------
    logic [10:0] w_chunk;
    logic        w_rom_ok;

    assign w_chunk  = ioctl_addr[24:14];
    assign w_rom_ok = 32'(w_chunk[10:2]) < 32'(NBANKS);

    // ---------------- per-byte routing ----------------
    logic [PAGE_W-1:0] w_mem_pg;
    logic [BANK_W-1:0] w_mem_bank;
    logic              w_mem_ok, w_free, w_go_mem, w_go_tape;

    always_comb begin
        w_mem_pg   = '0;
        w_mem_bank = '0;
        w_mem_ok   = 1'b0;
        if (w_in_rom) begin
            w_mem_pg   = to_page(ROM_PAGE_TBL[w_chunk[1:0]]);
            w_mem_bank = w_chunk[BANK_W+1:2];
            w_mem_ok   = w_rom_ok;
        end else if (w_in_ext) begin
            w_mem_pg   = w_ext_pg;
            w_mem_bank = model;
            w_mem_ok   = 1'b1;
        end
    end

    assign w_free    = w_wr_rise & ~w_pend_any & ~reset;
    assign w_go_mem  = w_free & w_mem_ok;
    assign w_go_tape = w_free & w_in_tap;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_page  <= '0;
            r_combo <= 1'b0;
            r_fixed <= 1'b0;
        end else if (w_dl_rise && w_in_idle && ioctl_index == C_IDX_EXT) begin
            r_page  <= to_page(w_ext_page9);
            r_combo <= w_ext_combo;
            r_fixed <= 1'b0;
        end else if (w_go_mem && w_in_ext && r_combo && ioctl_addr[15:0] == 16'h3FFF) begin
            r_page  <= to_page(PAGE_MF2);
            r_combo <= 1'b0;
            r_fixed <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset)                           ovf <= 1'b0;
        else if (w_wr_rise && w_pend_any)    ovf <= 1'b1;
    end

    // ---------------- channels ----------------
    logic [MEM_W-1:0]    w_mem_q;
    logic [ADDR_W+7:0]   w_tape_q;

    cpc_toggle_port #(.PAYLOAD_W(MEM_W)) u_mem_port (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .i_start   (w_go_mem),
        .i_payload ({w_mem_bank, w_mem_pg, ioctl_addr[13:0], ioctl_dout}),
        .i_ack     (mem_ack),
        .o_req     (mem_req),
        .o_pend    (w_mem_pend),
        .o_q       (w_mem_q)
    );

    cpc_toggle_port #(.PAYLOAD_W(ADDR_W + 8)) u_tape_port (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .i_start   (w_go_tape),
        .i_payload ({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
        .i_ack     (tape_ack),
        .o_req     (tape_req),
        .o_pend    (w_tape_pend),
        .o_q       (w_tape_q)
    );

    assign {mem_bank, mem_addr, mem_din} = w_mem_q;
    assign {tape_addr, tape_din}         = w_tape_q;
    assign ioctl_wait                    = w_pend_any;
    assign busy                          = ~w_in_idle | w_pend_any;

    // ---------------- ROM presence map (survives reset) ----------------
    logic [NBANKS*256-1:0] r_map;
    logic [BANK_W+7:0]     w_set_idx;

    assign w_set_idx = {w_mem_bank, w_mem_pg[7:0]};

    always_ff @(posedge clk_sys) begin
        if (map_clear)                          r_map            <= '0;
        else if (w_go_mem && w_mem_pg[PAGE_W-1]) r_map[w_set_idx] <= 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        map_hit <= r_map[{map_bank, map_page}];
    end

    logic w_unused_ext;
    assign w_unused_ext = ^ioctl_file_ext[31:16];

endmodule
`default_nettype wire
